// File: rtl/ysyx_22040088_ifu.sv
// Instruction fetch unit: holds the PC, issues one fetch at a time to instruction
// memory, and hands each fetched word with its PC to decode.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  REQ   | request valid at pc, waiting for memory to accept it
//  WAIT  | one fetch outstanding; drop_q marks it as squashed
//  HOLD  | instruction presented to decode, waiting for out_ready
module ysyx_22040088_ifu #(
    parameter int               XLEN     = 64,
    parameter logic [XLEN-1:0]  RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_inst_q, out_inst_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;

    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] pc_next_seq;
    logic [1:0]      unused_redirect_lsb;

    // Redirect targets are word aligned; the low two bits are dropped.
    assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsb = redirect_pc[1:0];
    assign pc_next_seq         = pc_q + {{(XLEN-3){1'b0}}, 3'b100};

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_q;
    assign out_valid      = out_valid_q;
    assign out_inst       = out_inst_q;
    assign out_pc         = out_pc_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;

        unique case (state_q)
            REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                    if (imem_req_ready) begin
                        state_d = WAIT;
                        drop_d  = 1'b1;
                    end
                end else if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                    if (imem_resp_valid) begin
                        state_d = REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (drop_q) begin
                        state_d = REQ;
                        drop_d  = 1'b0;
                    end else begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                        out_inst_d  = imem_resp_data;
                        out_pc_d    = pc_q;
                    end
                end
            end
            HOLD: begin
                // A redirect withdraws the held instruction even if decode is ready.
                if (redirect_valid) begin
                    state_d     = REQ;
                    out_valid_d = 1'b0;
                    pc_d        = redirect_target;
                end else if (out_ready) begin
                    state_d     = REQ;
                    out_valid_d = 1'b0;
                    pc_d        = pc_next_seq;
                end
            end
            default: begin
                state_d     = REQ;
                out_valid_d = 1'b0;
                drop_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_inst_q  <= NOP_INST;
            out_pc_q    <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
        end
    end

endmodule
